// File: rtl/id_stage_fwd.sv
// rtl/id_stage_fwd.sv - decode/register-read stage with EX/MEM/WB forwarding, load-use interlock and two-cycle branch FSM
// Optional feature macro: ID_WB_BYPASS_EN (same-cycle WB write-through into operand reads)
module id_stage_fwd #(
  parameter int unsigned       DATA_W      = 16,
  parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IR_VALID,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic              STALL_IN,
  input  logic              FLUSH_IN,
  input  logic              EX_VALID,
  input  logic              EX_WE,
  input  logic              EX_IS_LOAD,
  input  logic [2:0]        EX_DR,
  input  logic [DATA_W-1:0] EX_RESULT,
  input  logic              MEM_VALID,
  input  logic              MEM_WE,
  input  logic [2:0]        MEM_DR,
  input  logic [DATA_W-1:0] MEM_RESULT,
  input  logic              WB_ENABLE,
  input  logic [2:0]        DR_WB,
  input  logic [DATA_W-1:0] WB_RESULT,
  input  logic [2:0]        CC,
  output logic              STALL,
  output logic              VALID_OUT,
  output logic [1:0]        ALUOP,
  output logic [2:0]        DR,
  output logic [DATA_W-1:0] OPERAND1,
  output logic [DATA_W-1:0] OPERAND2,
  output logic [DATA_W-1:0] PC_OUT,
  output logic [DATA_W-1:0] PC_OFFSET,
  output logic [DATA_W-1:0] MEM_OFFSET,
  output logic              BRANCH
);

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LDW = 4'h6;
  localparam logic [3:0] OP_STW = 4'h7;

  typedef enum logic {
    S_DECODE,
    S_BR_HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] rf [8];

  logic [3:0]        opcode;
  logic              is_br;
  logic              is_add;
  logic              is_ldw;
  logic              is_stw;
  logic              add_imm;
  logic [2:0]        sr1;
  logic [2:0]        sr2;
  logic              use1;
  logic              use2;
  logic              ex_fwd_ok;
  logic              mem_fwd_ok;
  logic [DATA_W-1:0] src1_val;
  logic [DATA_W-1:0] src2_val;
  logic              load_use;
  logic              br_taken;
  logic              issue_valid;
  logic              issue_branch;
  logic [1:0]        aluop_dec;
  logic [DATA_W-1:0] op2_dec;
  logic [DATA_W-1:0] pc_offset_dec;
  logic [DATA_W-1:0] mem_offset_dec;
  logic [DATA_W-1:0] imm5_dec;

  assign opcode  = IR[15:12];
  assign is_br   = (opcode == OP_BR);
  assign is_add  = (opcode == OP_ADD);
  assign is_ldw  = (opcode == OP_LDW);
  assign is_stw  = (opcode == OP_STW);
  assign add_imm = is_add & IR[5];

  // STW reads its store-data register from the DR field
  assign sr1  = IR[8:6];
  assign sr2  = is_stw ? IR[11:9] : IR[2:0];
  assign use1 = is_add | is_ldw | is_stw;
  assign use2 = (is_add & ~IR[5]) | is_stw;

  assign pc_offset_dec  = {{(DATA_W-9){IR[8]}}, IR[8:0]};
  assign mem_offset_dec = {{(DATA_W-6){IR[5]}}, IR[5:0]};
  assign imm5_dec       = {{(DATA_W-5){IR[4]}}, IR[4:0]};

  // Register file; writes are never blocked by stall or flush
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= REG_RST_VAL;
      end
    end else if (WB_ENABLE) begin
      rf[DR_WB] <= WB_RESULT;
    end
  end

  // A load in EX has no data yet, so it is excluded here and handled by the interlock
  assign ex_fwd_ok  = EX_VALID & EX_WE & ~EX_IS_LOAD;
  assign mem_fwd_ok = MEM_VALID & MEM_WE;

  always_comb begin
    src1_val = rf[sr1];
    src2_val = rf[sr2];
`ifdef ID_WB_BYPASS_EN
    if (WB_ENABLE && (DR_WB == sr1)) src1_val = WB_RESULT;
    if (WB_ENABLE && (DR_WB == sr2)) src2_val = WB_RESULT;
`endif
    if (mem_fwd_ok && (MEM_DR == sr1)) src1_val = MEM_RESULT;
    if (mem_fwd_ok && (MEM_DR == sr2)) src2_val = MEM_RESULT;
    if (ex_fwd_ok && (EX_DR == sr1)) src1_val = EX_RESULT;
    if (ex_fwd_ok && (EX_DR == sr2)) src2_val = EX_RESULT;
  end

  assign load_use = (state == S_DECODE) & IR_VALID & EX_VALID & EX_IS_LOAD &
                    ((use1 & (EX_DR == sr1)) | (use2 & (EX_DR == sr2)));

  assign br_taken = (IR[11] & CC[2]) | (IR[10] & CC[1]) | (IR[9] & CC[0]);

  always_comb begin
    aluop_dec = 2'b00;
    case (opcode)
      OP_ADD:  aluop_dec = 2'b01;
      OP_LDW:  aluop_dec = 2'b10;
      OP_STW:  aluop_dec = 2'b11;
      default: aluop_dec = 2'b00;
    endcase
  end

  assign op2_dec = add_imm ? imm5_dec : src2_val;

  // Next state, upstream stall and issue decisions
  always_comb begin
    state_nxt    = state;
    STALL        = 1'b0;
    issue_valid  = 1'b0;
    issue_branch = 1'b0;
    if (FLUSH_IN) begin
      state_nxt = S_DECODE;
    end else if (STALL_IN) begin
      STALL = 1'b1;
    end else if (load_use) begin
      STALL = 1'b1;
    end else begin
      case (state)
        S_DECODE: begin
          if (IR_VALID && is_br) begin
            STALL     = 1'b1;
            state_nxt = S_BR_HOLD;
          end else if (IR_VALID) begin
            issue_valid = is_add | is_ldw | is_stw;
          end
        end
        S_BR_HOLD: begin
          issue_valid  = 1'b1;
          issue_branch = br_taken;
          state_nxt    = S_DECODE;
        end
        default: state_nxt = S_DECODE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_DECODE;
    end else begin
      state <= state_nxt;
    end
  end

  // ID/AGEX pipeline register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALID_OUT  <= 1'b0;
      BRANCH     <= 1'b0;
      ALUOP      <= 2'b00;
      DR         <= 3'b000;
      OPERAND1   <= '0;
      OPERAND2   <= '0;
      PC_OUT     <= '0;
      PC_OFFSET  <= '0;
      MEM_OFFSET <= '0;
    end else if (FLUSH_IN) begin
      VALID_OUT <= 1'b0;
      BRANCH    <= 1'b0;
    end else if (!STALL_IN) begin
      VALID_OUT  <= issue_valid;
      BRANCH     <= issue_branch;
      ALUOP      <= aluop_dec;
      DR         <= IR[11:9];
      OPERAND1   <= src1_val;
      OPERAND2   <= op2_dec;
      PC_OUT     <= PC_IN;
      PC_OFFSET  <= pc_offset_dec;
      MEM_OFFSET <= mem_offset_dec;
    end
  end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Parametrised successor to the 16-bit decode/register-read stage of the 5-stage LC-style pipeline.
- Decodes BR/ADD/LDW/STW and reads an 8-entry register file of DATA_W bits.
- Full EX/MEM/WB forwarding, load-use interlock, two-cycle branch resolution FSM, downstream hold and upstream flush.
- Sits between IF and AGEX; outputs are registered.

Parameters:
DATA_W, 16, datapath/register/PC width; must be >=16. The instruction is always 16 bits.
REG_RST_VAL, 0, value loaded into every register-file entry on reset.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
IR_VALID  input  1  IR holds a real instruction
IR  input  16  instruction; [15:12] opcode
PC_IN  input  DATA_W  PC of IR
STALL_IN  input  1  downstream hold
FLUSH_IN  input  1  kill instruction entering ID/AGEX register
EX_VALID, EX_WE, EX_IS_LOAD  input  1 each  AGEX-stage producer info
EX_DR  input  3  AGEX destination
EX_RESULT  input  DATA_W  AGEX result
MEM_VALID, MEM_WE  input  1 each  MEM-stage producer info
MEM_DR  input  3  MEM destination
MEM_RESULT  input  DATA_W  MEM result
WB_ENABLE  input  1  register-file write enable
DR_WB  input  3  write index
WB_RESULT  input  DATA_W  write data
CC  input  3  {N,Z,P}
STALL  output  1  upstream must hold IR/PC this cycle (combinational)
VALID_OUT  output  1  registered; outputs hold a real instruction
ALUOP  output  2  00 BR, 01 ADD, 10 LDW, 11 STW
DR  output  3  IR[11:9]
OPERAND1, OPERAND2  output  DATA_W  source operands; for STW, OPERAND2 is store data
PC_OUT, PC_OFFSET, MEM_OFFSET  output  DATA_W  PC; sext(IR[8:0]); sext(IR[5:0])
BRANCH  output  1  registered branch-taken

Behaviour:
- Reset (RST_N=0, async): all outputs 0, FSM=DECODE, every regfile entry=REG_RST_VAL.
- Decode:
  - SR1=IR[8:6].
  - SR2=IR[11:9] for STW, else IR[2:0].
  - ADD with IR[5]=1 takes OPERAND2=sext(IR[4:0]) to DATA_W.
- Sources used:
  - ADD-reg: SR1, SR2.
  - ADD-imm: SR1.
  - LDW: SR1.
  - STW: SR1, SR2.
  - BR: none.
  - Any other opcode is a NOP and issues VALID_OUT=0.
- Forwarding, per used source, priority EX > MEM > WB > regfile:
  - EX_VALID&EX_WE&!EX_IS_LOAD&EX_DR==src -> EX_RESULT.
  - MEM_VALID&MEM_WE&MEM_DR==src -> MEM_RESULT.
  - WB path: see the optional feature.
- Load-use: IR_VALID & EX_VALID & EX_IS_LOAD & EX_DR==any used source -> STALL=1, bubble issued (VALID_OUT<=0), FSM unchanged.
- Branch FSM:
  - DECODE: valid BR, not otherwise stalled -> STALL=1, bubble, go BR_HOLD.
  - BR_HOLD: STALL=0; issue BR with VALID_OUT=1, BRANCH<=(IR[11]&N)|(IR[10]&Z)|(IR[9]&P); go DECODE.
  - Non-BR instructions issue in one cycle with BRANCH<=0.
- STALL_IN=1: all output registers and FSM hold, STALL=1.
- Priority per cycle: reset > FLUSH_IN > STALL_IN > load-use > FSM/normal.
- FLUSH_IN=1: VALID_OUT<=0, BRANCH<=0, FSM<=DECODE, STALL=0; applies even with STALL_IN=1 or in BR_HOLD.
- Register-file write on WB_ENABLE occurs every cycle, independent of stall/flush.
- IR_VALID=0: bubble issued, no stall, FSM stays DECODE.
- Latency: 1 cycle non-BR, 2 cycles BR.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: same-cycle write-through. WB_ENABLE&DR_WB==src returns WB_RESULT, with priority below MEM.
- Undefined: regfile read returns the pre-write value. Software/scheduler must keep a 1-instruction gap from WB, and no WB comparator is built.

Test Plan:
- Reset with REG_RST_VAL=0, then ADD R1,R2,#-3 (IR=16'h12BD) -> next cycle VALID_OUT=1, ALUOP=01, DR=1, OPERAND1=0, OPERAND2=16'hFFFD.
- EX producing R2=16'h0005 and MEM producing R2=16'h0009 same cycle; ADD R3,R2,R2 -> OPERAND1=OPERAND2=16'h0005 (EX priority).
- EX_IS_LOAD with EX_DR=2; ID holds STW R2,R4,#1 -> STALL=1 one cycle, VALID_OUT=0; next cycle with the load in MEM (MEM_RESULT=16'h00AA) -> OPERAND2=16'h00AA.
- BRz #4 (IR=16'h0404), CC=010 -> cycle1 STALL=1, VALID_OUT=0; cycle2 VALID_OUT=1, BRANCH=1, PC_OFFSET=4. With CC=001 -> BRANCH=0.
- FLUSH_IN=1 while in BR_HOLD with STALL_IN=1 -> VALID_OUT=0, FSM=DECODE, STALL=0.
- With ID_WB_BYPASS_EN, WB writes R5=16'h1234 the same cycle as ADD R6,R5,#0 -> OPERAND1=16'h1234. Without the macro -> OPERAND1=the old R5 value.
